// File: rtl/rr_dispatch_if.sv
// Job handshake between the master's job source and the round-robin dispatcher.
// The dispatcher uses the slave modport; the job source uses the master modport.
interface rr_dispatch_if #(
  parameter int unsigned NUM_WRK = 16,
  parameter int unsigned IDX_W   = $clog2(NUM_WRK)
);
  logic               job_valid;
  logic               job_ready;
  logic [NUM_WRK-1:0] wrk_idle;
  logic [NUM_WRK-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;

  modport master (
    output job_valid,
    output wrk_idle,
    input  job_ready,
    input  grant,
    input  grant_idx
  );

  modport slave (
    input  job_valid,
    input  wrk_idle,
    output job_ready,
    output grant,
    output grant_idx
  );
endinterface

// File: rtl/rr_dispatch.sv
// Round-robin job dispatcher: hands each accepted job to one Julia worker via a
// one-cycle start pulse, in strict or skip-busy rotation, with a saturating stall counter.
module rr_dispatch #(
  parameter int unsigned NUM_WRK  = 16,
  parameter int unsigned INIT_IDX = 0,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned IDX_W   = $clog2(NUM_WRK)
) (
  input  logic               i_clk,
  input  logic               i_n_rst,
  input  logic               i_mode_skip,
  input  logic               i_flush,
  input  logic               i_clr_stats,
  rr_dispatch_if.slave       io_job,
  output logic [NUM_WRK-1:0] o_ptr,
  output logic [CNT_W-1:0]   o_stall_cnt
);

  localparam logic [NUM_WRK-1:0] ONE      = {{(NUM_WRK-1){1'b0}}, 1'b1};
  localparam logic [NUM_WRK-1:0] PTR_INIT = ONE << INIT_IDX;

  logic [NUM_WRK-1:0] r_ptr;
  logic [NUM_WRK-1:0] r_grant;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic [NUM_WRK-1:0] w_elig;
  logic [NUM_WRK-1:0] w_cand;
  logic [NUM_WRK-1:0] w_ptr_next;
  logic [IDX_W-1:0]   w_ptr_idx;
  logic [IDX_W-1:0]   w_cand_idx;
  logic               w_cand_vld;
  logic               w_ready;
  logic               w_xfer;
  logic               w_stall;

  // A worker pulsed last cycle has not yet had a chance to drop its idle flag.
  assign w_elig = io_job.wrk_idle & ~r_grant;

  always_comb begin
    w_ptr_idx = '0;
    for (int unsigned i = 0; i < NUM_WRK; i++) begin
      if (r_ptr[i]) w_ptr_idx = IDX_W'(i);
    end
  end

  always_comb begin
    int unsigned k;
    k          = 0;
    w_cand_vld = 1'b0;
    w_cand_idx = w_ptr_idx;
    if (!i_mode_skip) begin
      w_cand_vld = |(r_ptr & w_elig);
    end else begin
      for (int unsigned off = 0; off < NUM_WRK; off++) begin
        k = 32'(w_ptr_idx) + off;
        if (k >= NUM_WRK) k = k - NUM_WRK;
        if (!w_cand_vld && w_elig[IDX_W'(k)]) begin
          w_cand_vld = 1'b1;
          w_cand_idx = IDX_W'(k);
        end
      end
    end
  end

  assign w_cand     = w_cand_vld ? (ONE << w_cand_idx) : '0;
  assign w_ptr_next = {w_cand[NUM_WRK-2:0], w_cand[NUM_WRK-1]};

  assign w_ready = w_cand_vld & ~i_flush & i_n_rst;
  assign w_xfer  = io_job.job_valid & w_ready;
  assign w_stall = io_job.job_valid & ~w_ready;

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_ptr       <= PTR_INIT;
      r_grant     <= '0;
      r_grant_idx <= '0;
    end else if (i_flush) begin
      r_ptr   <= PTR_INIT;
      r_grant <= '0;
    end else if (w_xfer) begin
      r_ptr       <= w_ptr_next;
      r_grant     <= w_cand;
      r_grant_idx <= w_cand_idx;
    end else begin
      r_grant <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_stall_cnt <= '0;
    end else if (i_clr_stats) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign io_job.job_ready = w_ready;
  assign io_job.grant     = r_grant;
  assign io_job.grant_idx = r_grant_idx;
  assign o_ptr            = r_ptr;
  assign o_stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_rr_dispatch.sv
// Self-checking bench for rr_dispatch (4 workers, 4-bit stall counter) using a
// reference model that pushes expected outputs to a scoreboard queue each cycle.
module tb_rr_dispatch;
  localparam int unsigned NW = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned IW = 2;
  localparam logic [NW-1:0] ONE = 4'b0001;

  typedef struct packed {
    logic [NW-1:0] grant;
    logic [IW-1:0] idx;
    logic [NW-1:0] ptr;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          mode_skip = 1'b0;
  logic          flush = 1'b0;
  logic          clr_stats = 1'b0;
  logic [NW-1:0] ptr;
  logic [CW-1:0] stall_cnt;

  rr_dispatch_if #(.NUM_WRK(NW)) job_if ();

  rr_dispatch #(
    .NUM_WRK (NW),
    .INIT_IDX(0),
    .CNT_W   (CW)
  ) dut (
    .i_clk      (clk),
    .i_n_rst    (n_rst),
    .i_mode_skip(mode_skip),
    .i_flush    (flush),
    .i_clr_stats(clr_stats),
    .io_job     (job_if),
    .o_ptr      (ptr),
    .o_stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  logic [NW-1:0] m_ptr;
  logic [NW-1:0] m_grant;
  logic [IW-1:0] m_idx;
  logic [CW-1:0] m_cnt;

  function automatic void model_reset();
    m_ptr   = ONE;
    m_grant = '0;
    m_idx   = '0;
    m_cnt   = '0;
    sb_q.delete();
  endfunction

  // Returns the worker the dispatcher should pick this cycle, or -1.
  function automatic int m_cand();
    int p;
    int k;
    p = 0;
    for (int i = 0; i < NW; i++) if (m_ptr[i]) p = i;
    for (int off = 0; off < NW; off++) begin
      k = (p + off) % NW;
      if (job_if.wrk_idle[k] && !m_grant[k]) return k;
      if (!mode_skip) return -1;
    end
    return -1;
  endfunction

  // Predict the outcome of the coming clock edge, queue it, then advance past the edge.
  task automatic step();
    int   c;
    logic rdy;
    exp_t e;
    c       = m_cand();
    rdy     = (c >= 0) && !flush;
    e.grant = '0;
    if (flush) begin
      m_ptr = ONE;
    end else if (job_if.job_valid && rdy) begin
      e.grant = ONE << c;
      m_idx   = IW'(c);
      m_ptr   = ONE << ((c + 1) % NW);
    end
    if (clr_stats) m_cnt = '0;
    else if (job_if.job_valid && !rdy && (m_cnt != '1)) m_cnt = m_cnt + 1'b1;
    m_grant = e.grant;
    e.idx   = m_idx;
    e.ptr   = m_ptr;
    e.cnt   = m_cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, got;
    job_if.job_valid = 1'b1;
    job_if.wrk_idle  = '1;
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (job_if.job_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", job_if.job_ready);
    end
    checks++;
    if ({job_if.grant, ptr, stall_cnt} !== {4'b0000, 4'b0001, 4'h0}) begin
      errors++; $display("FAIL reset_state: got g=%b p=%b c=%0d want g=0000 p=0001 c=0",
                         job_if.grant, ptr, stall_cnt);
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      job_if.wrk_idle = (i == 0) ? 4'b0000 : 4'b1111;
      step();
      e = sb_q.pop_front();
      got = {job_if.grant, job_if.grant_idx, ptr, stall_cnt};
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL reset_pre_grant: got %h want %h", got, e);
      end
    end
    checks++;
    if (job_if.grant !== 4'b0001) begin
      errors++; $display("FAIL reset_grant_live: got %b want 0001", job_if.grant);
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if ({job_if.job_ready, job_if.grant, ptr, stall_cnt} !== {1'b0, 4'b0000, 4'b0001, 4'h0}) begin
      errors++; $display("FAIL reset_mid_grant: got r=%b g=%b p=%b c=%0d want r=0 g=0000 p=0001 c=0",
                         job_if.job_ready, job_if.grant, ptr, stall_cnt);
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
    model_reset();
  endtask

  task automatic test_strict_rotation();
    exp_t e, got;
    logic [NW-1:0] tbl_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int tbl_i [5] = '{0, 1, 2, 3, 0};
    mode_skip        = 1'b0;
    job_if.wrk_idle  = 4'b1111;
    job_if.job_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      e = sb_q.pop_front();
      got = {job_if.grant, job_if.grant_idx, ptr, stall_cnt};
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL strict_sb[%0d]: got %h want %h", i, got, e);
      end
      checks++;
      if ({job_if.grant, job_if.grant_idx} !== {tbl_g[i], IW'(tbl_i[i])}) begin
        errors++; $display("FAIL strict_seq[%0d]: got g=%b i=%0d want g=%b i=%0d",
                           i, job_if.grant, job_if.grant_idx, tbl_g[i], tbl_i[i]);
      end
    end
  endtask

  task automatic test_strict_stall();
    exp_t e, got;
    job_if.wrk_idle = 4'b1101;
    #1;
    checks++;
    if (job_if.job_ready !== 1'b0) begin
      errors++; $display("FAIL stall_ready: got %b want 0", job_if.job_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      e = sb_q.pop_front();
      got = {job_if.grant, job_if.grant_idx, ptr, stall_cnt};
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL stall_sb[%0d]: got %h want %h", i, got, e);
      end
    end
    job_if.wrk_idle = 4'b1111;
    #1;
    checks++;
    if (job_if.job_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release_ready: got %b want 1", job_if.job_ready);
    end
    step();
    e = sb_q.pop_front();
    got = {job_if.grant, job_if.grant_idx, ptr, stall_cnt};
    checks++;
    if (got !== e || job_if.grant !== 4'b0010 || ptr !== 4'b0100) begin
      errors++; $display("FAIL stall_release: got %h want %h (g=0010 p=0100)", got, e);
    end
  endtask

  task automatic test_skip_busy();
    exp_t e, got;
    for (int i = 0; i < 2; i++) begin
      flush = (i == 0);
      step();
      e = sb_q.pop_front();
      got = {job_if.grant, job_if.grant_idx, ptr, stall_cnt};
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL skip_setup[%0d]: got %h want %h", i, got, e);
      end
    end
    mode_skip       = 1'b1;
    job_if.wrk_idle = 4'b1001;
    #1;
    checks++;
    if (job_if.job_ready !== 1'b1) begin
      errors++; $display("FAIL skip_ready: got %b want 1", job_if.job_ready);
    end
    step();
    e = sb_q.pop_front();
    got = {job_if.grant, job_if.grant_idx, ptr, stall_cnt};
    checks++;
    if (got !== e || job_if.grant !== 4'b1000 || ptr !== 4'b0001) begin
      errors++; $display("FAIL skip_grant: got %h want %h (g=1000 p=0001)", got, e);
    end
    job_if.wrk_idle = 4'b0000;
    #1;
    checks++;
    if (job_if.job_ready !== 1'b0) begin
      errors++; $display("FAIL skip_none_ready: got %b want 0", job_if.job_ready);
    end
    step();
    e = sb_q.pop_front();
    got = {job_if.grant, job_if.grant_idx, ptr, stall_cnt};
    checks++;
    if (got !== e) begin
      errors++; $display("FAIL skip_none: got %h want %h", got, e);
    end
    // Mode change must affect job_ready in the same cycle.
    mode_skip       = 1'b0;
    job_if.wrk_idle = 4'b0100;
    #1;
    checks++;
    if (job_if.job_ready !== 1'b0) begin
      errors++; $display("FAIL mode_switch_strict: got %b want 0", job_if.job_ready);
    end
    mode_skip = 1'b1;
    #1;
    checks++;
    if (job_if.job_ready !== 1'b1) begin
      errors++; $display("FAIL mode_switch_skip: got %b want 1", job_if.job_ready);
    end
    step();
    e = sb_q.pop_front();
    got = {job_if.grant, job_if.grant_idx, ptr, stall_cnt};
    checks++;
    if (got !== e) begin
      errors++; $display("FAIL mode_switch_grant: got %h want %h", got, e);
    end
  endtask

  task automatic test_flush();
    exp_t e, got;
    job_if.wrk_idle = 4'b0010;
    step();
    e = sb_q.pop_front();
    got = {job_if.grant, job_if.grant_idx, ptr, stall_cnt};
    checks++;
    if (got !== e || ptr !== 4'b0100) begin
      errors++; $display("FAIL flush_setup: got %h want %h (p=0100)", got, e);
    end
    flush           = 1'b1;
    job_if.wrk_idle = 4'b1111;
    #1;
    checks++;
    if (job_if.job_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got %b want 0", job_if.job_ready);
    end
    step();
    e = sb_q.pop_front();
    got = {job_if.grant, job_if.grant_idx, ptr, stall_cnt};
    checks++;
    if (got !== e || job_if.grant !== 4'b0000 || ptr !== 4'b0001) begin
      errors++; $display("FAIL flush: got %h want %h (g=0000 p=0001)", got, e);
    end
    flush = 1'b0;
  endtask

  task automatic test_saturate();
    exp_t e, got;
    mode_skip        = 1'b0;
    job_if.wrk_idle  = 4'b0000;
    job_if.job_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      e = sb_q.pop_front();
      got = {job_if.grant, job_if.grant_idx, ptr, stall_cnt};
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL sat_sb[%0d]: got %h want %h", i, got, e);
      end
    end
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_value: got %0d want 15", stall_cnt);
    end
    clr_stats = 1'b1;
    step();
    e = sb_q.pop_front();
    got = {job_if.grant, job_if.grant_idx, ptr, stall_cnt};
    checks++;
    if (got !== e || stall_cnt !== 4'd0) begin
      errors++; $display("FAIL clr_priority: got %h want %h (c=0)", got, e);
    end
    clr_stats = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e, got;
    for (int i = 0; i < 300; i++) begin
      job_if.job_valid = ($urandom_range(0, 3) != 0);
      job_if.wrk_idle  = NW'($urandom);
      mode_skip        = (i >= 100) ? $urandom_range(0, 1) : 1'b1;
      flush            = ($urandom_range(0, 15) == 0);
      clr_stats        = ($urandom_range(0, 31) == 0);
      if (i < 40) job_if.wrk_idle = 4'b1111;
      step();
      e = sb_q.pop_front();
      got = {job_if.grant, job_if.grant_idx, ptr, stall_cnt};
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL random[%0d]: got g=%b i=%0d p=%b c=%0d want g=%b i=%0d p=%b c=%0d",
                           i, got.grant, got.idx, got.ptr, got.cnt, e.grant, e.idx, e.ptr, e.cnt);
      end
    end
    flush     = 1'b0;
    clr_stats = 1'b0;
  endtask

  initial begin
    job_if.job_valid = 1'b0;
    job_if.wrk_idle  = '0;
    model_reset();
    test_reset();
    test_strict_rotation();
    test_strict_stall();
    test_skip_busy();
    test_flush();
    test_saturate();
    test_back_to_back();
    job_if.job_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
